// File: rtl/matmul_tile_sequencer_if.sv
// Handshake and address bus between the tile sequencer and the matmul core.
// The sequencer drives start, addresses and accumulate controls; the core returns done.
interface matmul_tile_sequencer_if #(
   parameter int unsigned AWIDTH = 10
);
   logic              start_mat_mul;
   logic              done_mat_mul;
   logic [AWIDTH-1:0] address_mat_a;
   logic [AWIDTH-1:0] address_mat_b;
   logic [AWIDTH-1:0] address_mat_c;
   logic              save_output_to_accum;
   logic              add_accum_to_output;

   modport master (
      output start_mat_mul,
      output address_mat_a,
      output address_mat_b,
      output address_mat_c,
      output save_output_to_accum,
      output add_accum_to_output,
      input  done_mat_mul
   );

   modport slave (
      input  start_mat_mul,
      input  address_mat_a,
      input  address_mat_b,
      input  address_mat_c,
      input  save_output_to_accum,
      input  add_accum_to_output,
      output done_mat_mul
   );
endinterface

// File: rtl/matmul_tile_sequencer.sv
// Walks M x N x K tiles (k innermost), issuing one core operation per tile with
// incrementally generated A/B/C base addresses, K-accumulation controls and a watchdog.
module matmul_tile_sequencer #(
   parameter int unsigned AWIDTH            = 10,
   parameter int unsigned ADDR_STRIDE_WIDTH = 8,
   parameter int unsigned CNT_WIDTH         = 4,
   parameter int unsigned TIMEOUT_CYCLES    = 1024,
   parameter int unsigned TO_WIDTH          = 11
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         start_reg,
   input  logic                         clear_done_reg,
   input  logic [AWIDTH-1:0]            addr_a_base,
   input  logic [AWIDTH-1:0]            addr_b_base,
   input  logic [AWIDTH-1:0]            addr_c_base,
   input  logic [ADDR_STRIDE_WIDTH-1:0] a_m_step,
   input  logic [ADDR_STRIDE_WIDTH-1:0] a_k_step,
   input  logic [ADDR_STRIDE_WIDTH-1:0] b_k_step,
   input  logic [ADDR_STRIDE_WIDTH-1:0] b_n_step,
   input  logic [ADDR_STRIDE_WIDTH-1:0] c_m_step,
   input  logic [ADDR_STRIDE_WIDTH-1:0] c_n_step,
   input  logic [CNT_WIDTH-1:0]         num_m_tiles,
   input  logic [CNT_WIDTH-1:0]         num_n_tiles,
   input  logic [CNT_WIDTH-1:0]         num_k_tiles,
   matmul_tile_sequencer_if.master      core,
   output logic                         busy,
   output logic                         done_reg,
   output logic                         cfg_err,
   output logic                         timeout_err,
   output logic [CNT_WIDTH-1:0]         m_idx,
   output logic [CNT_WIDTH-1:0]         n_idx,
   output logic [CNT_WIDTH-1:0]         k_idx
);

   localparam int unsigned AW = AWIDTH;
   localparam int unsigned SW = ADDR_STRIDE_WIDTH;
   localparam int unsigned CW = CNT_WIDTH;
   localparam int unsigned TW = TO_WIDTH;
   localparam logic [TW-1:0] TO_LAST =
      TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_GAP, S_ADVANCE, S_DONE
   } state_t;

   state_t state_q, state_d;

   // Configuration captured at start
   logic [AW-1:0] base_a_q, base_a_d, base_b_q, base_b_d, base_c_q, base_c_d;
   logic [SW-1:0] a_m_q, a_m_d, a_k_q, a_k_d, b_k_q, b_k_d;
   logic [SW-1:0] b_n_q, b_n_d, c_m_q, c_m_d, c_n_q, c_n_d;
   logic [CW-1:0] m_cnt_q, m_cnt_d, n_cnt_q, n_cnt_d, k_cnt_q, k_cnt_d;

   // Walk state
   logic [AW-1:0] row_a_q, row_a_d, row_c_q, row_c_d, col_b_q, col_b_d;
   logic [AW-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d, addr_c_q, addr_c_d;
   logic [CW-1:0] m_q, m_d, n_q, n_d, k_q, k_d;
   logic [TW-1:0] wd_q, wd_d;
   logic          start_q, start_d, save_q, save_d, add_q, add_d;
   logic          busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;
   logic          to_err_q, to_err_d;

   logic k_last, n_last, m_last;

   assign k_last = (k_q == k_cnt_q - CW'(1));
   assign n_last = (n_q == n_cnt_q - CW'(1));
   assign m_last = (m_q == m_cnt_q - CW'(1));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         base_a_q  <= '0; base_b_q <= '0; base_c_q <= '0;
         a_m_q     <= '0; a_k_q    <= '0; b_k_q    <= '0;
         b_n_q     <= '0; c_m_q    <= '0; c_n_q    <= '0;
         m_cnt_q   <= '0; n_cnt_q  <= '0; k_cnt_q  <= '0;
         row_a_q   <= '0; row_c_q  <= '0; col_b_q  <= '0;
         addr_a_q  <= '0; addr_b_q <= '0; addr_c_q <= '0;
         m_q       <= '0; n_q      <= '0; k_q      <= '0;
         wd_q      <= '0;
         start_q   <= 1'b0; save_q <= 1'b0; add_q <= 1'b0;
         busy_q    <= 1'b0; done_q <= 1'b0;
         cfg_err_q <= 1'b0; to_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         base_a_q  <= base_a_d; base_b_q <= base_b_d; base_c_q <= base_c_d;
         a_m_q     <= a_m_d;    a_k_q    <= a_k_d;    b_k_q    <= b_k_d;
         b_n_q     <= b_n_d;    c_m_q    <= c_m_d;    c_n_q    <= c_n_d;
         m_cnt_q   <= m_cnt_d;  n_cnt_q  <= n_cnt_d;  k_cnt_q  <= k_cnt_d;
         row_a_q   <= row_a_d;  row_c_q  <= row_c_d;  col_b_q  <= col_b_d;
         addr_a_q  <= addr_a_d; addr_b_q <= addr_b_d; addr_c_q <= addr_c_d;
         m_q       <= m_d;      n_q      <= n_d;      k_q      <= k_d;
         wd_q      <= wd_d;
         start_q   <= start_d;  save_q   <= save_d;   add_q    <= add_d;
         busy_q    <= busy_d;   done_q   <= done_d;
         cfg_err_q <= cfg_err_d; to_err_q <= to_err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      base_a_d  = base_a_q; base_b_d = base_b_q; base_c_d = base_c_q;
      a_m_d     = a_m_q;    a_k_d    = a_k_q;    b_k_d    = b_k_q;
      b_n_d     = b_n_q;    c_m_d    = c_m_q;    c_n_d    = c_n_q;
      m_cnt_d   = m_cnt_q;  n_cnt_d  = n_cnt_q;  k_cnt_d  = k_cnt_q;
      row_a_d   = row_a_q;  row_c_d  = row_c_q;  col_b_d  = col_b_q;
      addr_a_d  = addr_a_q; addr_b_d = addr_b_q; addr_c_d = addr_c_q;
      m_d       = m_q;      n_d      = n_q;      k_d      = k_q;
      wd_d      = wd_q;
      start_d   = start_q;  save_d   = save_q;   add_d    = add_q;
      done_d    = done_q;   cfg_err_d = cfg_err_q; to_err_d = to_err_q;

      case (state_q)
         S_IDLE: begin
            if (start_reg) begin
               base_a_d = addr_a_base; base_b_d = addr_b_base; base_c_d = addr_c_base;
               a_m_d    = a_m_step;    a_k_d    = a_k_step;    b_k_d    = b_k_step;
               b_n_d    = b_n_step;    c_m_d    = c_m_step;    c_n_d    = c_n_step;
               m_cnt_d  = num_m_tiles; n_cnt_d  = num_n_tiles; k_cnt_d  = num_k_tiles;
               state_d  = S_CHECK;
            end
         end
         S_CHECK: begin
            if (m_cnt_q == '0 || n_cnt_q == '0 || k_cnt_q == '0) begin
               cfg_err_d = 1'b1;
               done_d    = 1'b1;
               state_d   = S_DONE;
            end else begin
               m_d      = '0; n_d = '0; k_d = '0;
               row_a_d  = base_a_q; col_b_d  = base_b_q; row_c_d  = base_c_q;
               addr_a_d = base_a_q; addr_b_d = base_b_q; addr_c_d = base_c_q;
               state_d  = S_ISSUE;
            end
         end
         S_ISSUE: begin
            start_d = 1'b1;
            save_d  = !k_last;
            add_d   = (k_q != '0);
            wd_d    = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // Core done takes priority over a watchdog expiring in the same cycle
            if (core.done_mat_mul) begin
               start_d = 1'b0;
               state_d = S_GAP;
            end else if (TIMEOUT_CYCLES != 0 && wd_q == TO_LAST) begin
               start_d  = 1'b0;
               to_err_d = 1'b1;
               done_d   = 1'b1;
               state_d  = S_DONE;
            end else if (TIMEOUT_CYCLES != 0) begin
               wd_d = wd_q + TW'(1);
            end
         end
         S_GAP: begin
            if (!core.done_mat_mul) state_d = S_ADVANCE;
         end
         S_ADVANCE: begin
            state_d = S_ISSUE;
            if (!k_last) begin
               k_d      = k_q + CW'(1);
               addr_a_d = addr_a_q + AW'(a_k_q);
               addr_b_d = addr_b_q + AW'(b_k_q);
            end else if (!n_last) begin
               k_d      = '0;
               n_d      = n_q + CW'(1);
               addr_a_d = row_a_q;
               col_b_d  = col_b_q + AW'(b_n_q);
               addr_b_d = col_b_q + AW'(b_n_q);
               addr_c_d = addr_c_q + AW'(c_n_q);
            end else if (!m_last) begin
               k_d      = '0;
               n_d      = '0;
               m_d      = m_q + CW'(1);
               row_a_d  = row_a_q + AW'(a_m_q);
               addr_a_d = row_a_q + AW'(a_m_q);
               col_b_d  = base_b_q;
               addr_b_d = base_b_q;
               row_c_d  = row_c_q + AW'(c_m_q);
               addr_c_d = row_c_q + AW'(c_m_q);
            end else begin
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            // Clear wins over a simultaneous start; start is re-sampled in IDLE
            if (clear_done_reg) begin
               done_d    = 1'b0;
               cfg_err_d = 1'b0;
               to_err_d  = 1'b0;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = !(state_d == S_IDLE || state_d == S_DONE);
   end

   assign core.start_mat_mul        = start_q;
   assign core.address_mat_a        = addr_a_q;
   assign core.address_mat_b        = addr_b_q;
   assign core.address_mat_c        = addr_c_q;
   assign core.save_output_to_accum = save_q;
   assign core.add_accum_to_output  = add_q;

   assign busy        = busy_q;
   assign done_reg    = done_q;
   assign cfg_err     = cfg_err_q;
   assign timeout_err = to_err_q;
   assign m_idx       = m_q;
   assign n_idx       = n_q;
   assign k_idx       = k_q;

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// Directed bench for matmul_tile_sequencer: tile walks, accumulate flags, address wrap,
// zero-count config error, watchdog expiry, async reset mid-run and clear/start priority.
module tb_matmul_tile_sequencer;
   localparam int unsigned AW = 10;
   localparam int unsigned SW = 8;
   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          start_reg = 1'b0;
   logic          clear_done_reg = 1'b0;
   logic [AW-1:0] addr_a_base = '0, addr_b_base = '0, addr_c_base = '0;
   logic [SW-1:0] a_m_step = '0, a_k_step = '0, b_k_step = '0;
   logic [SW-1:0] b_n_step = '0, c_m_step = '0, c_n_step = '0;
   logic [CW-1:0] num_m_tiles = '0, num_n_tiles = '0, num_k_tiles = '0;
   logic          busy, done_reg, cfg_err, timeout_err;
   logic [CW-1:0] m_idx, n_idx, k_idx;

   int   n_pass = 0;
   int   n_total = 0;
   int   start_count = 0;
   logic start_prev = 1'b0;
   int   s0;
   int   cyc;

   matmul_tile_sequencer_if #(.AWIDTH(AW)) core_bus ();

   matmul_tile_sequencer #(
      .AWIDTH(AW), .ADDR_STRIDE_WIDTH(SW), .CNT_WIDTH(CW),
      .TIMEOUT_CYCLES(50), .TO_WIDTH(11)
   ) dut (
      .clk(clk), .resetn(resetn),
      .start_reg(start_reg), .clear_done_reg(clear_done_reg),
      .addr_a_base(addr_a_base), .addr_b_base(addr_b_base), .addr_c_base(addr_c_base),
      .a_m_step(a_m_step), .a_k_step(a_k_step), .b_k_step(b_k_step),
      .b_n_step(b_n_step), .c_m_step(c_m_step), .c_n_step(c_n_step),
      .num_m_tiles(num_m_tiles), .num_n_tiles(num_n_tiles), .num_k_tiles(num_k_tiles),
      .core(core_bus),
      .busy(busy), .done_reg(done_reg), .cfg_err(cfg_err), .timeout_err(timeout_err),
      .m_idx(m_idx), .n_idx(n_idx), .k_idx(k_idx)
   );

   always #5 clk = ~clk;

   // Counts core start rising edges
   always @(posedge clk) begin
      if (core_bus.start_mat_mul && !start_prev) start_count <= start_count + 1;
      start_prev <= core_bus.start_mat_mul;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "bench hung");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic set_cfg(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] c,
                          input logic [SW-1:0] am, input logic [SW-1:0] ak, input logic [SW-1:0] bk,
                          input logic [SW-1:0] bn, input logic [SW-1:0] cm, input logic [SW-1:0] cn,
                          input logic [CW-1:0] m, input logic [CW-1:0] n, input logic [CW-1:0] k);
      addr_a_base = a;  addr_b_base = b;  addr_c_base = c;
      a_m_step = am;    a_k_step = ak;    b_k_step = bk;
      b_n_step = bn;    c_m_step = cm;    c_n_step = cn;
      num_m_tiles = m;  num_n_tiles = n;  num_k_tiles = k;
   endtask

   task automatic pulse_start;
      start_reg = 1'b1;
      tick();
      start_reg = 1'b0;
   endtask

   task automatic clear_done;
      clear_done_reg = 1'b1;
      tick();
      clear_done_reg = 1'b0;
   endtask

   task automatic wait_start(input string tag);
      int i = 0;
      while (!core_bus.start_mat_mul && i < 200) begin
         tick();
         i++;
      end
      check({tag, "_start_seen"}, 32'(core_bus.start_mat_mul), 32'd1);
   endtask

   task automatic wait_done(input string tag);
      int i = 0;
      while (!done_reg && i < 200) begin
         tick();
         i++;
      end
      check({tag, "_done"}, 32'(done_reg), 32'd1);
      check({tag, "_busy_low"}, 32'(busy), 32'd0);
   endtask

   // One core operation: check issued tile, respond with done after lat cycles
   task automatic run_tile(input string tag, input logic [AW-1:0] ea, input logic [AW-1:0] eb,
                           input logic [AW-1:0] ec, input logic es, input logic ed,
                           input logic [CW-1:0] em, input logic [CW-1:0] en,
                           input logic [CW-1:0] ek, input int lat);
      wait_start(tag);
      check({tag, "_addr_a"}, 32'(core_bus.address_mat_a), 32'(ea));
      check({tag, "_addr_b"}, 32'(core_bus.address_mat_b), 32'(eb));
      check({tag, "_addr_c"}, 32'(core_bus.address_mat_c), 32'(ec));
      check({tag, "_save_add"},
            32'({core_bus.save_output_to_accum, core_bus.add_accum_to_output}), 32'({es, ed}));
      check({tag, "_idx"}, 32'({m_idx, n_idx, k_idx}), 32'({em, en, ek}));
      repeat (lat) tick();
      core_bus.done_mat_mul = 1'b1;
      tick();
      check({tag, "_start_drop"}, 32'(core_bus.start_mat_mul), 32'd0);
      core_bus.done_mat_mul = 1'b0;
   endtask

   initial begin
      core_bus.done_mat_mul = 1'b0;
      tick();
      tick();
      check("reset_outputs",
            32'({core_bus.start_mat_mul, busy, done_reg, cfg_err, timeout_err,
                 core_bus.save_output_to_accum, core_bus.add_accum_to_output}), 32'd0);
      check("reset_addr", 32'({core_bus.address_mat_a, core_bus.address_mat_c}), 32'd0);
      resetn = 1'b1;
      tick();

      // Single tile, 20-cycle core
      set_cfg(10'h000, 10'h100, 10'h200, 0, 0, 0, 0, 0, 0, 1, 1, 1);
      s0 = start_count;
      pulse_start();
      run_tile("t1", 10'h000, 10'h100, 10'h200, 1'b0, 1'b0, 0, 0, 0, 20);
      wait_done("t1");
      check("t1_start_count", 32'(start_count - s0), 32'd1);
      clear_done();
      check("t1_cleared", 32'(done_reg), 32'd0);

      // K accumulation
      set_cfg(10'h000, 10'h100, 10'h200, 0, 4, 16, 0, 0, 0, 1, 1, 3);
      s0 = start_count;
      pulse_start();
      run_tile("t2_k0", 10'h000, 10'h100, 10'h200, 1'b1, 1'b0, 0, 0, 0, 3);
      run_tile("t2_k1", 10'h004, 10'h110, 10'h200, 1'b1, 1'b1, 0, 0, 1, 0);
      run_tile("t2_k2", 10'h008, 10'h120, 10'h200, 1'b0, 1'b1, 0, 0, 2, 5);
      wait_done("t2");
      check("t2_start_count", 32'(start_count - s0), 32'd3);
      clear_done();

      // 2x2 output tiles, m and n stepping
      set_cfg(10'h000, 10'h100, 10'h200, 16, 0, 0, 4, 16, 4, 2, 2, 1);
      pulse_start();
      run_tile("t3_m0n0", 10'h000, 10'h100, 10'h200, 1'b0, 1'b0, 0, 0, 0, 2);
      run_tile("t3_m0n1", 10'h000, 10'h104, 10'h204, 1'b0, 1'b0, 0, 1, 0, 2);
      run_tile("t3_m1n0", 10'h010, 10'h100, 10'h210, 1'b0, 1'b0, 1, 0, 0, 2);
      run_tile("t3_m1n1", 10'h010, 10'h104, 10'h214, 1'b0, 1'b0, 1, 1, 0, 2);
      wait_done("t3");
      clear_done();

      // Address wrap modulo 2^AWIDTH
      set_cfg(10'h3F8, 10'h100, 10'h200, 0, 8'h10, 0, 0, 0, 0, 1, 1, 2);
      pulse_start();
      run_tile("wrap_k0", 10'h3F8, 10'h100, 10'h200, 1'b1, 1'b0, 0, 0, 0, 1);
      run_tile("wrap_k1", 10'h008, 10'h100, 10'h200, 1'b0, 1'b1, 0, 0, 1, 1);
      wait_done("wrap");
      clear_done();

      // Zero tile count
      set_cfg(10'h000, 10'h100, 10'h200, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      s0 = start_count;
      pulse_start();
      wait_done("t4");
      check("t4_cfg_err", 32'(cfg_err), 32'd1);
      check("t4_no_start", 32'(start_count - s0), 32'd0);
      clear_done();
      check("t4_flags_clear", 32'({done_reg, cfg_err, timeout_err, busy}), 32'd0);

      // Watchdog: core never answers
      set_cfg(10'h000, 10'h100, 10'h200, 0, 0, 0, 0, 0, 0, 1, 1, 1);
      pulse_start();
      wait_start("t5");
      cyc = 0;
      while (core_bus.start_mat_mul && cyc < 200) begin
         tick();
         cyc++;
      end
      check("t5_wait_cycles", 32'(cyc), 32'd50);
      check("t5_timeout_err", 32'(timeout_err), 32'd1);
      check("t5_done", 32'(done_reg), 32'd1);
      clear_done();
      check("t5_cleared", 32'({timeout_err, done_reg}), 32'd0);

      // Async reset during WAIT of tile 2, then full restart
      set_cfg(10'h000, 10'h100, 10'h200, 0, 4, 16, 0, 0, 0, 1, 1, 3);
      pulse_start();
      run_tile("t6_k0", 10'h000, 10'h100, 10'h200, 1'b1, 1'b0, 0, 0, 0, 1);
      run_tile("t6_k1", 10'h004, 10'h110, 10'h200, 1'b1, 1'b1, 0, 0, 1, 1);
      wait_start("t6_k2");
      check("t6_k2_idx", 32'(k_idx), 32'd2);
      #2 resetn = 1'b0;
      #1;
      check("t6_rst_ctrl",
            32'({core_bus.start_mat_mul, busy, done_reg,
                 core_bus.save_output_to_accum, core_bus.add_accum_to_output}), 32'd0);
      check("t6_rst_addr", 32'({core_bus.address_mat_a, core_bus.address_mat_b, k_idx}), 32'd0);
      tick();
      resetn = 1'b1;
      tick();
      pulse_start();
      run_tile("t6r_k0", 10'h000, 10'h100, 10'h200, 1'b1, 1'b0, 0, 0, 0, 1);
      run_tile("t6r_k1", 10'h004, 10'h110, 10'h200, 1'b1, 1'b1, 0, 0, 1, 1);
      run_tile("t6r_k2", 10'h008, 10'h120, 10'h200, 1'b0, 1'b1, 0, 0, 2, 1);
      wait_done("t6r");

      // Clear and start together: clear wins, start taken from IDLE next cycle
      clear_done_reg = 1'b1;
      start_reg = 1'b1;
      tick();
      clear_done_reg = 1'b0;
      check("t6_clr_idle", 32'({done_reg, busy}), 32'd0);
      tick();
      start_reg = 1'b0;
      check("t6_check_busy", 32'(busy), 32'd1);
      run_tile("t6c_k0", 10'h000, 10'h100, 10'h200, 1'b1, 1'b0, 0, 0, 0, 0);
      run_tile("t6c_k1", 10'h004, 10'h110, 10'h200, 1'b1, 1'b1, 0, 0, 1, 0);
      run_tile("t6c_k2", 10'h008, 10'h120, 10'h200, 1'b0, 1'b1, 0, 0, 2, 0);
      wait_done("t6c");
      clear_done();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
